// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-line round-robin arbiter and its
// rotating priority search.
package arb_pkg;

  localparam int NUM_LINES = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  typedef logic [NUM_LINES-1:0] onehot_t;
  typedef logic [IDX_W-1:0]     idx_t;

  // Line index after i, wrapping 7 -> 0 through the natural 3-bit overflow.
  function automatic idx_t next_idx(idx_t i);
    return i + idx_t'(1);
  endfunction

endpackage

// File: rtl/round_robin_arbiter_8_if.sv
// Request/grant bundle between the requesting lines (master) and the
// arbiter (slave).
interface round_robin_arbiter_8_if;
  import arb_pkg::*;

  onehot_t req_lines;
  logic    release_in;
  onehot_t grant_lines;
  logic    grant_valid;
  logic    timeout_pulse;

  modport master (
    output req_lines,
    output release_in,
    input  grant_lines,
    input  grant_valid,
    input  timeout_pulse
  );

  modport slave (
    input  req_lines,
    input  release_in,
    output grant_lines,
    output grant_valid,
    output timeout_pulse
  );

endinterface

// File: rtl/rr_pick.sv
// Rotating first-set search: the lowest-numbered request at or above ptr,
// wrapping 7 -> 0, reported as an index and as a one-hot vector.
module rr_pick
  import arb_pkg::*;
(
  input  onehot_t req,
  input  idx_t    ptr,
  output logic    found,
  output idx_t    idx,
  output onehot_t onehot
);

  always_comb begin
    idx_t cand;
    // NOTE: every output gets a default before the search loop; without it,
    // the no-request path would leave them unassigned and infer latches.
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      cand = ptr + idx_t'(i);
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_robin_arbiter_8.sv
// Registered round-robin arbiter: one-hot grant held until release, request
// drop or hold timeout, with a mandatory idle cycle between grants.
module round_robin_arbiter_8 #(
  parameter int NUM_LINES = 8,
  parameter int MAX_HOLD  = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  round_robin_arbiter_8_if.slave arb
);
  import arb_pkg::*;

  // A zero MAX_HOLD disables the timeout; keep the counter at least 1 bit.
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  arb_state_e           state;
  idx_t                 ptr;
  idx_t                 owner;
  logic [CNT_W-1:0]     hold_cnt;
  onehot_t              grant_q;
  logic                 valid_q;
  logic                 pulse_q;

  logic                 pick_found;
  idx_t                 pick_idx;
  logic [NUM_LINES-1:0] pick_onehot;

  logic                 end_release;
  logic                 end_drop;
  logic                 end_timeout;
  logic                 end_any;

  rr_pick u_pick (
    .req    (arb.req_lines),
    .ptr    (ptr),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign end_release = arb.release_in;
  assign end_drop    = !arb.req_lines[owner];
  assign end_timeout = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign end_any     = end_release || end_drop || end_timeout;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            state    <= ST_GRANT;
            owner    <= pick_idx;
            grant_q  <= pick_onehot;
            valid_q  <= 1'b1;
            hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (end_any) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr     <= next_idx(owner);
            // Only a pure timeout is reported; a coincident release or drop wins.
            pulse_q <= end_timeout && !end_release && !end_drop;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign arb.grant_lines   = grant_q;
  assign arb.grant_valid   = valid_q;
  assign arb.timeout_pulse = pulse_q;

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Self-checking bench: two arbiters (MAX_HOLD 4 and 16) on shared stimulus,
// each compared every cycle against a cycle-count reference model.
module tb_round_robin_arbiter_8;
  import arb_pkg::*;

  localparam int HOLD_A = 4;
  localparam int HOLD_B = 16;

  typedef struct {
    bit busy;   // a grant is being shown
    int owner;  // line holding it
    int prio;   // line searched first when idle
    int held;   // cycles the current grant has been visible
    bit pulse;  // timeout reported this cycle
  } model_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       rel;
  int         checks   = 0;
  int         failures = 0;
  model_t     m_a;
  model_t     m_b;

  round_robin_arbiter_8_if if_a ();
  round_robin_arbiter_8_if if_b ();

  assign if_a.req_lines  = req;
  assign if_a.release_in = rel;
  assign if_b.req_lines  = req;
  assign if_b.release_in = rel;

  round_robin_arbiter_8 #(.NUM_LINES(8), .MAX_HOLD(HOLD_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (if_a)
  );

  round_robin_arbiter_8 #(.NUM_LINES(8), .MAX_HOLD(HOLD_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  function automatic model_t model_reset();
    model_t m;
    m.busy  = 1'b0;
    m.owner = 0;
    m.prio  = 0;
    m.held  = 0;
    m.pulse = 1'b0;
    return m;
  endfunction

  // One rising edge of the arbiter, from the rules: pick, hold, end, rotate.
  function automatic model_t model_step(model_t m, logic [7:0] r, logic rl, int max_hold);
    model_t n = m;
    n.pulse = 1'b0;
    if (!m.busy) begin
      for (int k = 0; k < 8; k++) begin
        int c = (m.prio + k) % 8;
        if (!n.busy && r[c]) begin
          n.busy  = 1'b1;
          n.owner = c;
          n.held  = 1;
        end
      end
    end else begin
      bit by_rel;
      bit by_drop;
      bit by_time;
      by_rel  = rl;
      by_drop = !r[m.owner];
      by_time = (max_hold != 0) && (m.held == max_hold);
      if (by_rel || by_drop || by_time) begin
        n.busy  = 1'b0;
        n.prio  = (m.owner + 1) % 8;
        n.pulse = by_time && !by_rel && !by_drop;
      end else begin
        n.held = m.held + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] model_grant(model_t m);
    return m.busy ? (8'h01 << m.owner) : 8'h00;
  endfunction

  task automatic compare_all();
    check("a.grant", if_a.grant_lines, model_grant(m_a));
    check("a.valid", if_a.grant_valid, m_a.busy);
    check("a.pulse", if_a.timeout_pulse, m_a.pulse);
    check("a.onehot0", 32'($onehot0(if_a.grant_lines)), 1);
    check("b.grant", if_b.grant_lines, model_grant(m_b));
    check("b.valid", if_b.grant_valid, m_b.busy);
    check("b.pulse", if_b.timeout_pulse, m_b.pulse);
    check("b.onehot0", 32'($onehot0(if_b.grant_lines)), 1);
  endtask

  // Advance one clock; inputs were set away from the edge and are stable here.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      m_a = model_reset();
      m_b = model_reset();
    end else begin
      m_a = model_step(m_a, req, rel, HOLD_A);
      m_b = model_step(m_b, req, rel, HOLD_B);
    end
    @(negedge clk);
    compare_all();
  endtask

  // Assert reset between edges and confirm the outputs clear before the next edge.
  task automatic async_reset(input string tag);
    #1 rst_n = 1'b0;
    #1;
    check({tag, ".a.grant"}, if_a.grant_lines, 0);
    check({tag, ".a.valid"}, if_a.grant_valid, 0);
    check({tag, ".b.grant"}, if_b.grant_lines, 0);
    check({tag, ".b.valid"}, if_b.grant_valid, 0);
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    rel   = 1'b0;
    m_a   = model_reset();
    m_b   = model_reset();

    // Reset and idle with no requests.
    repeat (2) @(negedge clk);
    check("rst.grant", if_a.grant_lines, 0);
    check("rst.valid", if_a.grant_valid, 0);
    check("rst.pulse", if_a.timeout_pulse, 0);
    rst_n = 1'b1;
    repeat (4) cycle();
    check("idle.grant", if_a.grant_lines, 0);

    // Rotation with every line requesting and release held high.
    req = 8'hFF;
    rel = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      check("rot.grant", if_a.grant_lines, 8'h01 << (i % 8));
      if (i == 8) req = 8'h00;
      cycle();
      check("rot.gap", if_a.grant_lines, 0);
    end
    rel = 1'b0;

    // Single requester, then a release that moves priority to line 3.
    req = 8'h04;
    cycle();
    check("single.grant", if_a.grant_lines, 8'h04);
    cycle();
    check("single.hold", if_a.grant_lines, 8'h04);
    rel = 1'b1;
    req = 8'h0C;
    cycle();
    check("single.drop", if_a.grant_lines, 0);
    rel = 1'b0;
    cycle();
    check("single.ptr3", if_a.grant_lines, 8'h08);
    rel = 1'b1;
    req = 8'h00;
    cycle();
    rel = 1'b0;

    // Timeout on dut_a: four visible cycles, one pulsed gap, re-grant.
    req = 8'h80;
    for (int i = 0; i < HOLD_A; i++) begin
      cycle();
      check("to.grant", if_a.grant_lines, 8'h80);
      check("to.nopulse", if_a.timeout_pulse, 0);
    end
    cycle();
    check("to.gap", if_a.grant_lines, 0);
    check("to.pulse", if_a.timeout_pulse, 1);
    cycle();
    check("to.regrant", if_a.grant_lines, 8'h80);
    check("to.pulse_off", if_a.timeout_pulse, 0);

    // Release on the same edge the hold limit is reached: no pulse.
    repeat (HOLD_A - 1) cycle();
    rel = 1'b1;
    cycle();
    check("sim.grant", if_a.grant_lines, 0);
    check("sim.pulse", if_a.timeout_pulse, 0);
    rel = 1'b0;

    // Mid-grant asynchronous reset, then arbitration restarts from line 0.
    req = 8'h10;
    cycle();
    check("mid.grant", if_a.grant_lines, 8'h10);
    async_reset("mid.rst");
    req = 8'h11;
    cycle();
    check("mid.after", if_a.grant_lines, 8'h01);

    // No preemption by other lines; owner drop hands over via an idle cycle.
    req = 8'h1F;
    cycle();
    check("nopre.1", if_a.grant_lines, 8'h01);
    cycle();
    check("nopre.2", if_a.grant_lines, 8'h01);
    req = 8'h14;
    cycle();
    check("drop.gap", if_a.grant_lines, 0);
    check("drop.pulse", if_a.timeout_pulse, 0);
    cycle();
    check("drop.next", if_a.grant_lines, 8'h04);
    rel = 1'b1;
    req = 8'h00;
    cycle();
    rel = 1'b0;

    // Randomized traffic with slowly changing requests and sparse releases.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 0) req = 8'($urandom);
        else                        req = 8'($urandom) & 8'($urandom) & 8'($urandom);
      end
      rel = ($urandom_range(7) == 0);
      if ($urandom_range(249) == 0) async_reset("rnd.rst");
      else                          cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_robin_arbiter_8.md
# round_robin_arbiter_8

Registered round-robin arbiter that resolves up to eight request lines into a single one-hot grant vector. It sits directly upstream of the team's 8-to-3 encoder. Its grant vector is always zero or strictly one-hot, so it can drive the encoder's input lines unmodified. A grant is held until the owner releases it, drops its request, or exceeds a hold limit. Priority then rotates to the next line.

## Interface
- `NUM_LINES`, default 8: number of request/grant lines; fixed at 8 for this block.
- `MAX_HOLD`, default 16: maximum cycles a grant may be held; 0 disables the timeout.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_lines`  in  8  request per line, level-sensitive.
- `release_in`  in  1  current owner finished; sampled only while granting.
- `grant_lines`  out  8  registered grant; always 0 or one-hot.
- `grant_valid`  out  1  high when `grant_lines` is non-zero.
- `timeout_pulse`  out  1  one-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- State machine with two states: IDLE and GRANT.
- Internal state:
  - `ptr`: 3-bit highest-priority index.
  - `owner`: 3-bit index of the current grant holder.
  - `hold_cnt`: counter of width clog2(MAX_HOLD+1).
- Reset value of every output is 0. Internal reset: state IDLE, `ptr`=0, `hold_cnt`=0.
- In IDLE:
  - If `req_lines`==0, stay in IDLE; outputs remain 0.
  - Otherwise, the winner is the first set bit scanning upward from `ptr`, wrapping 7→0.
  - Next state is GRANT, with `grant_lines` = 1<<winner, `owner` = winner, `grant_valid`=1, `hold_cnt`=0.
- In GRANT, each cycle evaluate the end conditions:
  - (a) `release_in`=1;
  - (b) `req_lines[owner]`=0;
  - (c) `MAX_HOLD`≠0 and `hold_cnt`==MAX_HOLD-1.
- If any end condition holds:
  - Next state is IDLE; `grant_lines`=0, `grant_valid`=0.
  - `ptr` = (owner+1) mod 8, wrapping from 7 to 0.
  - `timeout_pulse`=1 for one cycle only when (c) holds and neither (a) nor (b) holds.
- If no end condition holds, `hold_cnt` increments and the grant is unchanged.
- Requests from non-owner lines during GRANT are ignored; they cannot preempt the owner.
- `release_in` is ignored in IDLE.
- Asserting `rst_n` low mid-grant clears all outputs immediately (asynchronously). After reset, arbitration restarts with `ptr`=0.

## Timing
- Request-to-grant latency is 1 cycle: a request sampled at edge k is visible on `grant_lines` after edge k.
- Release-to-drop latency is 1 cycle: `release_in` sampled at edge k clears `grant_lines` after edge k.
- At least one IDLE cycle (all-zero grant) separates consecutive grants, so the downstream encoder never sees two bits set during a handover.
- With `MAX_HOLD`=M, an unreleased grant is visible for exactly M cycles. `timeout_pulse` coincides with the first zero-grant cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `arb_pkg` holds:
  - `NUM_LINES`;
  - `IDX_W`=3;
  - the state enum {`ST_IDLE`, `ST_GRANT`};
  - a `onehot_t` 8-bit typedef.
- One combinational sub-module, `rr_pick`:
  - inputs: `req[7:0]`, `ptr[2:0]`;
  - outputs: `found`, `idx[2:0]`, `onehot[7:0]`;
  - implements the rotating first-set search.
- The FSM, counter and registers live in the top module.

## Test plan
- Reset/idle: `rst_n`=0, then release, with `req_lines`=0 → all outputs 0 indefinitely; `ptr`=0.
- Single requester: `req_lines`=8'b00000100 → `grant_lines`=8'b00000100 one cycle later. `release_in` pulse → grant goes to 0 next cycle, and `ptr` becomes 3.
- Rotation: `req_lines`=8'hFF held, `release_in` pulsed on every grant cycle. Grants must appear in the order 0x01, 0x02, 0x04 … 0x80, then 0x01 (wrap-around), each separated by one zero cycle.
- Timeout: `MAX_HOLD`=4, `req_lines`=8'b10000000 held, no release. Expected sequence:
  - grant 0x80 for exactly 4 cycles;
  - then 0 with `timeout_pulse`=1 for one cycle;
  - then re-grant 0x80.
- Simultaneous events: `release_in`=1 on the same cycle `hold_cnt` reaches MAX_HOLD-1 → grant drops, `timeout_pulse` stays 0. Owner dropping its request while another line requests → no preemption until the IDLE cycle, after which the next line above the owner wins.
- Mid-grant reset: drive `rst_n` low while `grant_lines`=0x10 → outputs are 0 before the next clock edge. After release, with `req_lines`=0x11, the grant is 0x01 (`ptr` reset to 0).
